// File: rtl/sa_result_collector.sv
// Collects the skewed per-lane outputs of the systolic array into an ARRAY_SIZE x ARRAY_SIZE
// result buffer and serves it as packed two-entry words through a one-cycle-latency read port.
module sa_result_collector #(
    parameter int ARRAY_SIZE = 3,
    parameter int OUT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [ARRAY_SIZE*OUT_W-1:0] sa_out,
    input  logic                        rd_en,
    input  logic [3:0]                  rd_addr,
    output logic [2*OUT_W-1:0]          rd_data,
    output logic                        rd_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    localparam int N      = ARRAY_SIZE * ARRAY_SIZE;
    localparam int WORDS  = (N + 1) / 2;
    localparam int BEAT_W = $clog2(2 * ARRAY_SIZE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2 * ARRAY_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [N*OUT_W-1:0]       buf_q, buf_d;
    logic                     overrun_q, overrun_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [2*OUT_W-1:0]       rd_data_q, rd_data_d;
    logic                     rd_valid_q, rd_valid_d;
    logic [2*WORDS*OUT_W-1:0] buf_pad_s;
    logic [2*OUT_W-1:0]       rd_word_s;

    // Capture FSM: lane k, row r lands on beat k+r+1, which undoes the array's diagonal skew.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        buf_d     = buf_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = CAPTURE;
                    beat_d    = '0;
                    buf_d     = '0;
                    overrun_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            CAPTURE: begin
                if (start) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                for (int k = 0; k < ARRAY_SIZE; k++) begin
                    for (int r = 0; r < ARRAY_SIZE; r++) begin
                        if (in_valid && (beat_q == BEAT_W'(k + r + 1))) begin
                            buf_d[(k*ARRAY_SIZE+r)*OUT_W +: OUT_W] = sa_out[k*OUT_W +: OUT_W];
                        end else begin
                            buf_d[(k*ARRAY_SIZE+r)*OUT_W +: OUT_W] = buf_q[(k*ARRAY_SIZE+r)*OUT_W +: OUT_W];
                        end
                    end
                end
                if (in_valid) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CAPTURE);
        done_d = (state_d == DONE);
    end

    // Read port: word lookup from the pre-write buffer, so a same-cycle write is not visible yet.
    always_comb begin
        buf_pad_s             = '0;
        buf_pad_s[N*OUT_W-1:0] = buf_q;
        rd_word_s             = '0;
        for (int w = 0; w < WORDS; w++) begin
            rd_word_s |= (rd_addr == 4'(w)) ? buf_pad_s[w*2*OUT_W +: 2*OUT_W] : '0;
        end
        if (rd_en) begin
            rd_data_d = rd_word_s;
        end else begin
            rd_data_d = rd_data_q;
        end
        rd_valid_d = rd_en;
    end

    // State, buffer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            buf_q      <= '0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            buf_q      <= buf_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule
